// File: rtl/dac_output_controller.sv
// dac_output_controller
// Converts a millivolt setpoint (valid/ready) into an unsigned WIDTH-bit DAC code
// by inverse scaling, rounding and saturation. The code drives the R2R ladder
// output and a free-running PWM generator.
// Build option: define DAC_SLEW_LIMIT_EN to add the SLEW state and update-tick
// counter, which limit the code change to SLEW_STEP per tick. Without it the
// rounded target is loaded straight into the output code.
module dac_output_controller #(
    parameter int unsigned WIDTH         = 8,
    parameter int unsigned CLOCK_FREQ    = 100_000_000,
    parameter int unsigned UPDATE_FREQ   = 2000,
    parameter int unsigned FULL_SCALE_MV = 3300,
    parameter int unsigned INV_SCALE     = 5064,
    parameter int unsigned SHIFT         = 16,
    parameter int unsigned SLEW_STEP     = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sp_valid,
    input  logic [15:0]      sp_mv,
    output logic             sp_ready,
    input  logic             dac_en,
    output logic [WIDTH-1:0] r2r_out,
    output logic             pwm_out,
    output logic [WIDTH-1:0] code_out,
    output logic             busy,
    output logic             settled,
    output logic             sat_flag
);

    localparam logic [WIDTH-1:0] MAX_CODE   = '1;
    localparam logic [32:0]      MAX_CODE_W = 33'(MAX_CODE);
    localparam logic [32:0]      ROUND_BIAS = 33'(1) << (SHIFT - 1);

`ifdef DAC_SLEW_LIMIT_EN
    typedef enum logic [1:0] {IDLE, MULT, ROUND, SLEW} state_t;
`else
    typedef enum logic [1:0] {IDLE, MULT, ROUND} state_t;
`endif

    state_t           state;
    logic [15:0]      mv_q;
    logic [31:0]      product;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] current;
    logic [WIDTH-1:0] current_nxt;
    logic             sat_q;
    logic             accept;

    logic [32:0]      rounded;
    logic [32:0]      scaled;
    logic [WIDTH-1:0] round_code;
    logic             round_sat;

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] duty;
    logic [WIDTH-1:0] duty_nxt;
    logic             pwm_q;
    logic [WIDTH-1:0] r2r_q;

`ifdef DAC_SLEW_LIMIT_EN
    localparam int unsigned      TICK_DIV  = CLOCK_FREQ / UPDATE_FREQ;
    localparam int unsigned      TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [WIDTH-1:0] STEP      = WIDTH'(SLEW_STEP);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic [WIDTH-1:0]  gap;
    logic [WIDTH-1:0]  step_code;

    assign sp_ready = !reset && (state == IDLE || state == SLEW);
    assign tick     = (tick_cnt == TICK_LAST);

    // Free-running update-tick divider; accepts do not restart it
    always_ff @(posedge clk) begin
        if (reset || tick) tick_cnt <= '0;
        else               tick_cnt <= tick_cnt + 1'b1;
    end

    // One slew step toward target, limited to STEP
    always_comb begin
        gap       = '0;
        step_code = current;
        if (target > current) begin
            gap       = target - current;
            step_code = current + ((gap > STEP) ? STEP : gap);
        end else if (current > target) begin
            gap       = current - target;
            step_code = current - ((gap > STEP) ? STEP : gap);
        end
    end
`else
    assign sp_ready = !reset && (state == IDLE);
`endif

    assign accept = sp_valid && sp_ready;

    // Round, shift and saturate the registered product into a code
    always_comb begin
        rounded   = {1'b0, product} + ROUND_BIAS;
        scaled    = rounded >> SHIFT;
        round_sat = (32'(mv_q) > FULL_SCALE_MV);
        if (round_sat || scaled > MAX_CODE_W) round_code = MAX_CODE;
        else                                  round_code = scaled[WIDTH-1:0];
    end

    // Next output code; shared by the code register and the R2R register
    always_comb begin
        current_nxt = current;
`ifdef DAC_SLEW_LIMIT_EN
        // A retarget accept on a tick edge wins: no step is taken
        if (state == SLEW && tick && !accept) current_nxt = step_code;
`else
        if (state == ROUND) current_nxt = round_code;
`endif
    end

    // Setpoint FSM: accept, multiply, round, optional slew
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            mv_q    <= '0;
            product <= '0;
            target  <= '0;
            current <= '0;
            sat_q   <= 1'b0;
        end else begin
            current <= current_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        mv_q  <= sp_mv;
                        state <= MULT;
                    end
                end
                MULT: begin
                    product <= 32'(mv_q) * INV_SCALE;
                    state   <= ROUND;
                end
                ROUND: begin
                    target <= round_code;
                    sat_q  <= round_sat;
`ifdef DAC_SLEW_LIMIT_EN
                    state  <= SLEW;
`else
                    state  <= IDLE;
`endif
                end
`ifdef DAC_SLEW_LIMIT_EN
                SLEW: begin
                    if (accept) begin
                        mv_q  <= sp_mv;
                        state <= MULT;
                    end else if (current == target) begin
                        state <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign cnt_nxt  = cnt + 1'b1;
    assign duty_nxt = (cnt == MAX_CODE) ? current : duty;

    // PWM: duty reloads only at the period boundary, output registered
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            duty  <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            duty  <= duty_nxt;
            pwm_q <= dac_en && (cnt_nxt < duty_nxt);
        end
    end

    // R2R register, updated on the same edge as the code
    always_ff @(posedge clk) begin
        if (reset) r2r_q <= '0;
        else       r2r_q <= dac_en ? current_nxt : '0;
    end

    assign r2r_out  = r2r_q;
    assign pwm_out  = pwm_q;
    assign code_out = current;
    assign sat_flag = sat_q;
    assign busy     = (state != IDLE);
    assign settled  = (state == IDLE) && (current == target);

endmodule

// File: tb/tb_dac_output_controller.sv
// Self-checking bench for dac_output_controller: table-driven setpoint vectors
// plus hand-written sequences for reset, PWM periods, slew steps and dac_en.
module tb_dac_output_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        sp_valid;
    logic [15:0] sp_mv;
    logic        sp_ready;
    logic        dac_en;
    logic [7:0]  r2r_out;
    logic        pwm_out;
    logic [7:0]  code_out;
    logic        busy;
    logic        settled;
    logic        sat_flag;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [15:0] mv;
        logic [7:0]  code;
        logic        sat;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    dac_output_controller #(
        .WIDTH        (8),
        .CLOCK_FREQ   (100_000_000),
        .UPDATE_FREQ  (10_000_000),
        .FULL_SCALE_MV(3300),
        .INV_SCALE    (5064),
        .SHIFT        (16),
        .SLEW_STEP    (4)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sp_valid(sp_valid),
        .sp_mv   (sp_mv),
        .sp_ready(sp_ready),
        .dac_en  (dac_en),
        .r2r_out (r2r_out),
        .pwm_out (pwm_out),
        .code_out(code_out),
        .busy    (busy),
        .settled (settled),
        .sat_flag(sat_flag)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Present a setpoint; returns 1ns after the accepting edge
    task automatic send(input logic [15:0] mv);
        int waited = 0;
        @(negedge clk);
        sp_mv    = mv;
        sp_valid = 1'b1;
        while (!sp_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("handshake ready", {31'd0, sp_ready}, 32'd1);
        @(posedge clk);
        #1 sp_valid = 1'b0;
    endtask

    task automatic wait_settled();
        int i = 0;
        while (!(settled && !busy) && i < 4000) begin
            @(posedge clk);
            #1 i++;
        end
        check("settle timeout", {31'd0, settled}, 32'd1);
    endtask

    task automatic count_pwm(input int n, output int highs);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1 if (pwm_out) highs++;
        end
    endtask

    task automatic wait_change(input logic [7:0] prev, output logic [7:0] val, output int cycles);
        cycles = 0;
        while (code_out == prev && cycles < 100) begin
            @(posedge clk);
            #1 cycles++;
        end
        val = code_out;
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          highs;
        int          cyc;
        logic [7:0]  val;
        logic [7:0]  prev_code;
        logic        prev_pwm;
        int          guard;

        vecs[0] = '{16'd3300,  8'd255, 1'b0};
        vecs[1] = '{16'd1000,  8'd77,  1'b0};
        vecs[2] = '{16'd5000,  8'd255, 1'b1};
        vecs[3] = '{16'd0,     8'd0,   1'b0};
        vecs[4] = '{16'd3301,  8'd255, 1'b1};
        vecs[5] = '{16'd130,   8'd10,  1'b0};
        vecs[6] = '{16'd65535, 8'd255, 1'b1};
        vecs[7] = '{16'd0,     8'd0,   1'b0};

        // Reset held with sp_valid high
        reset    = 1'b1;
        sp_valid = 1'b1;
        sp_mv    = 16'd1000;
        dac_en   = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset sp_ready", {31'd0, sp_ready}, 32'd0);
        check("reset r2r_out",  {24'd0, r2r_out},  32'd0);
        check("reset pwm_out",  {31'd0, pwm_out},  32'd0);
        check("reset code_out", {24'd0, code_out}, 32'd0);
        check("reset busy",     {31'd0, busy},     32'd0);
        check("reset settled",  {31'd0, settled},  32'd1);
        check("reset sat_flag", {31'd0, sat_flag}, 32'd0);
        sp_valid = 1'b0;
        reset    = 1'b0;
        @(posedge clk);
        #1 check("sp_ready after release", {31'd0, sp_ready}, 32'd1);

        // Table-driven setpoints
        prev_code = 8'd0;
        for (int unsigned k = 0; k < 8; k++) begin
            send(vecs[k].mv);
            check("busy after accept", {31'd0, busy}, 32'd1);
`ifndef DAC_SLEW_LIMIT_EN
            @(posedge clk);
            #1 check("code held at N+1", {24'd0, code_out}, {24'd0, prev_code});
            @(posedge clk);
            #1 check("code at N+2", {24'd0, code_out}, {24'd0, vecs[k].code});
            check("r2r at N+2", {24'd0, r2r_out}, {24'd0, vecs[k].code});
`endif
            wait_settled();
            check("vec code_out", {24'd0, code_out}, {24'd0, vecs[k].code});
            check("vec r2r_out",  {24'd0, r2r_out},  {24'd0, vecs[k].code});
            check("vec sat_flag", {31'd0, sat_flag}, {31'd0, vecs[k].sat});
            check("vec busy",     {31'd0, busy},     32'd0);
            prev_code = vecs[k].code;
        end

        // Reset mid-operation drops the in-flight setpoint
        send(16'd1000);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1 check("abort code_out", {24'd0, code_out}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);

        // PWM duty 64/256
        send(16'd828);
        wait_settled();
        check("pwm code 64", {24'd0, code_out}, 32'd64);
        repeat (600) @(posedge clk);
        #1 count_pwm(256, highs);
        check("pwm 64 highs", highs, 32'd64);

`ifndef DAC_SLEW_LIMIT_EN
        // Retarget mid-period: old duty finishes, new duty from next period
        prev_pwm = pwm_out;
        guard    = 0;
        while (!(prev_pwm && !pwm_out) && guard < 600) begin
            prev_pwm = pwm_out;
            @(posedge clk);
            #1 guard++;
        end
        check("pwm falling edge found", {31'd0, (guard < 600)}, 32'd1);
        send(16'd2485);
        count_pwm(188, highs);
        check("pwm old period tail low", highs, 32'd0);
        check("pwm code 192", {24'd0, code_out}, 32'd192);
        repeat (20) @(posedge clk);
        #1 count_pwm(256, highs);
        check("pwm 192 highs", highs, 32'd192);
`endif

`ifdef DAC_SLEW_LIMIT_EN
        // Slew 0 -> 10 in steps of 4, then retarget to 2 from 8
        send(16'd0);
        wait_settled();
        send(16'd130);
        wait_change(8'd0, val, cyc);
        check("slew step 1", {24'd0, val}, 32'd4);
        wait_change(val, val, cyc);
        check("slew step 2", {24'd0, val}, 32'd8);
        check("slew tick spacing", cyc, 32'd10);
        wait_change(val, val, cyc);
        check("slew step 3", {24'd0, val}, 32'd10);
        wait_settled();
        check("slew settled busy", {31'd0, busy}, 32'd0);
        send(16'd26);
        wait_change(8'd10, val, cyc);
        check("reslew to 6", {24'd0, val}, 32'd6);
        send(16'd130);
        wait_change(val, val, cyc);
        check("back up to 10", {24'd0, val}, 32'd10);
        wait_settled();
        send(16'd130);
        wait_settled();
        send(16'd0);
        wait_settled();
        send(16'd130);
        wait_change(8'd0, val, cyc);
        wait_change(val, val, cyc);
        check("at 8 before retarget", {24'd0, val}, 32'd8);
        send(16'd26);
        wait_change(8'd8, val, cyc);
        check("retarget step 1", {24'd0, val}, 32'd4);
        wait_change(val, val, cyc);
        check("retarget step 2", {24'd0, val}, 32'd2);
        wait_settled();
        check("retarget busy", {31'd0, busy}, 32'd0);
`endif

        // dac_en gating
        send(16'd1656);
        wait_settled();
        check("en code 128", {24'd0, code_out}, 32'd128);
        check("en r2r 128",  {24'd0, r2r_out},  32'd128);
        @(negedge clk);
        dac_en = 1'b0;
        @(posedge clk);
        #1 check("disabled r2r", {24'd0, r2r_out}, 32'd0);
        check("disabled code", {24'd0, code_out}, 32'd128);
        count_pwm(300, highs);
        check("disabled pwm highs", highs, 32'd0);
        send(16'd828);
        wait_settled();
        check("disabled accept code", {24'd0, code_out}, 32'd64);
        check("disabled accept r2r",  {24'd0, r2r_out},  32'd0);
        @(negedge clk);
        dac_en = 1'b1;
        @(posedge clk);
        #1 check("reenable r2r", {24'd0, r2r_out}, 32'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dac_output_controller.md
# dac_output_controller

Output-side counterpart to the ADC chain. It accepts a millivolt setpoint over a valid/ready handshake and inverse-scales it to an unsigned WIDTH-bit DAC code, rounding and saturating the result. The code drives the R2R ladder directly and an on-chip PWM generator in parallel, with optional slew limiting. It sits beside the ADC paths at top level and is fed by the menu subsystem from the switches or a scaled ADC reading, for loop-back testing.

## Interface
- WIDTH, 8: DAC code width.
- CLOCK_FREQ, 100_000_000: clock frequency in Hz.
- UPDATE_FREQ, 2000: slew update rate in Hz.
- FULL_SCALE_MV, 3300: setpoint mapped to code 2^WIDTH-1.
- INV_SCALE, 5064: code = (mv*INV_SCALE + 2^(SHIFT-1)) >> SHIFT.
- SHIFT, 16: right-shift applied after the multiply.
- SLEW_STEP, 4: maximum code change per update tick.
- clk  input  1  system clock; the block uses one clock.
- reset  input  1  synchronous, active-high reset.
- sp_valid  input  1  setpoint valid.
- sp_mv  input  16  setpoint in mV, unsigned.
- sp_ready  output  1  block can accept a setpoint.
- dac_en  input  1  output enable.
- r2r_out  output  WIDTH  R2R ladder code.
- pwm_out  output  1  PWM DAC output.
- code_out  output  WIDTH  current code, present regardless of dac_en.
- busy  output  1  conversion or slew in progress.
- settled  output  1  current code equals target code and state is IDLE.
- sat_flag  output  1  last accepted setpoint exceeded FULL_SCALE_MV.

## Operation
- The FSM has four states: IDLE, MULT, ROUND, SLEW.
- sp_ready is 1 in IDLE and in SLEW, 0 in MULT and ROUND, and forced to 0 while reset is high.
- Accept: on the edge where sp_valid && sp_ready, latch sp_mv and go to MULT.
  - An accept during SLEW retargets; the current code holds until the new target is computed.
- MULT: register a 32-bit product sp_mv*INV_SCALE, then go to ROUND.
- ROUND: add 2^(SHIFT-1), shift right by SHIFT, and load the target.
  - If the latched sp_mv > FULL_SCALE_MV, target = 2^WIDTH-1 and sat_flag=1. Otherwise sat_flag=0.
  - A shifted result above 2^WIDTH-1 also clamps to 2^WIDTH-1.
  - Go to SLEW, or with slew limiting compiled out, load current = target and go to IDLE.
- SLEW: on each tick, current moves toward target by min(SLEW_STEP, |target-current|). When current == target, go to IDLE.
- Tick: a free-running counter over 0..CLOCK_FREQ/UPDATE_FREQ-1 pulses tick for one cycle at its terminal count. The counter is not restarted by an accept.
- busy = (state != IDLE). settled = (state == IDLE) && (current == target).
- PWM:
  - A free-running WIDTH-bit counter cnt increments every clock.
  - duty is loaded from current when cnt == 2^WIDTH-1.
  - pwm_out = dac_en && (cnt < duty).
  - duty 0 gives constant low; the maximum duty gives high for 2^WIDTH-1 of every 2^WIDTH clocks.
- dac_en=0 forces r2r_out=0 and pwm_out=0. The FSM, the code and the handshake keep operating; outputs resume on the cycle after dac_en returns to 1.

## Timing
- Reset values:
  - state IDLE, current 0, target 0, duty 0, cnt 0, tick counter 0.
  - r2r_out=0, pwm_out=0, code_out=0, busy=0, settled=1, sat_flag=0.
  - sp_ready=1 from the first cycle after reset deasserts.
- Reset asserted mid-operation aborts immediately, with no completion of the in-flight setpoint.
- Latency: accept at edge N, target valid after edge N+2.
  - Without slew limiting, code_out and r2r_out change after edge N+2.
  - pwm_out reflects the new code from the next PWM period boundary.
- r2r_out = dac_en ? current : 0, registered, with the same-cycle update as code_out.
- Simultaneous tick and retarget accept: the accept wins and no step is taken on that edge.
- A tick during MULT or ROUND is ignored.

## Configuration
- DAC_SLEW_LIMIT_EN defined: the SLEW state and tick counter are present and the code steps by SLEW_STEP per tick.
- DAC_SLEW_LIMIT_EN undefined: there is no SLEW state and no tick counter. ROUND loads current directly; busy is high only in MULT and ROUND; SLEW_STEP and UPDATE_FREQ are ignored.

## Test plan
- Reset test: assert reset with sp_valid high. Required: all outputs at reset values and sp_ready=0 during reset; sp_ready=1 on the first cycle after release.
- Slew compiled out, sp_mv=3300: code_out=255 exactly 2 edges after accept and sat_flag=0. Then sp_mv=1000: code_out=77.
- sp_mv=5000: code_out=255 and sat_flag=1. The next setpoint, 0, gives code_out=0 and sat_flag=0.
- PWM with code 64: pwm_out is high for 64 of every 256 clocks. Change the code to 192 mid-period: the old duty finishes and 192/256 applies from the next period.
- Slew defined with UPDATE_FREQ overridden so the tick period is 10 clocks: going 0 to target 10 gives code_out 4, 8, 10 on three consecutive ticks, then settled=1 and busy=0. Retarget to 2 while the code is at 8: the code goes to 4, then 2.
- dac_en=0 while the code is 128: r2r_out=0 and pwm_out stays low, code_out=128, and a setpoint is still accepted. On re-enable, r2r_out equals code_out on the next cycle.
